// File: rtl/period_meter.sv
// Period and high-time meter for an asynchronous input, measured in CLK cycles.
// One result record per closed period, delivered through a single-entry
// valid/ready output slot with a sticky drop indicator.
module period_meter #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 SIG,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 ovf,
  output logic                 lost
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_q, rise;
  logic [CNT_WIDTH-1:0]   pcnt, pcnt_nxt;
  logic [CNT_WIDTH-1:0]   hcnt, hcnt_nxt;
  logic [CNT_WIDTH-1:0]   res_period, res_high;
  logic                   res_emit, res_ovf;
  logic                   accept, load, discard;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_q;

  // Synchroniser chain plus previous-value register for edge detection; runs regardless of en.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SIG};
      s_q    <= s;
    end
  end

  // FSM state and measurement counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      pcnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // Next-state, counter update and result emission; a rise at pcnt==MAX wins over the timeout.
  always_comb begin
    state_nxt  = state;
    pcnt_nxt   = pcnt;
    hcnt_nxt   = hcnt;
    res_emit   = 1'b0;
    res_ovf    = 1'b0;
    res_period = pcnt;
    res_high   = hcnt;
    if (!en) begin
      state_nxt = IDLE;
      pcnt_nxt  = '0;
      hcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          pcnt_nxt = '0;
          hcnt_nxt = '0;
          if (rise) begin
            pcnt_nxt  = CNT_ONE;
            hcnt_nxt  = CNT_ONE;
            state_nxt = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            res_emit = 1'b1;
            pcnt_nxt = CNT_ONE;
            hcnt_nxt = CNT_ONE;
          end else if (pcnt == CNT_MAX) begin
            res_emit  = 1'b1;
            res_ovf   = 1'b1;
            pcnt_nxt  = '0;
            hcnt_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            pcnt_nxt = pcnt + CNT_ONE;
            if (s && (hcnt != CNT_MAX)) hcnt_nxt = hcnt + CNT_ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign accept  = m_valid & m_ready;
  assign load    = res_emit & (~m_valid | m_ready);
  assign discard = res_emit & m_valid & ~m_ready;

  // Single-entry output slot: holds data under backpressure, flags dropped results.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_valid   <= 1'b0;
      period    <= '0;
      high_time <= '0;
      ovf       <= 1'b0;
      lost      <= 1'b0;
    end else begin
      if (load) begin
        m_valid   <= 1'b1;
        period    <= res_period;
        high_time <= res_high;
        ovf       <= res_ovf;
      end else if (accept) begin
        m_valid <= 1'b0;
      end
      if (discard)     lost <= 1'b1;
      else if (accept) lost <= 1'b0;
    end
  end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of an asynchronous digital input, counted in CLK cycles. The input is typically a divided clock or tick stream produced by the counter blocks. Each complete period yields one result record, delivered over a valid/ready interface to a register bank or stream consumer. The input is synchronised internally and measurements saturate cleanly.

## Interface
- CNT_WIDTH, 16, width of the period and high-time fields; minimum 2
- SYNC_STAGES, 2, number of synchroniser flops on SIG; minimum 2
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- en  in  1  measurement enable
- SIG  in  1  asynchronous signal being measured
- m_ready  in  1  consumer can accept a result
- m_valid  out  1  result available
- period  out  CNT_WIDTH  CLK cycles between consecutive rising edges of SIG
- high_time  out  CNT_WIDTH  CLK cycles SIG was high within that period
- ovf  out  1  result is a timeout or saturation record, not a true period
- lost  out  1  at least one result was dropped since the last accepted result

## Operation
- SIG passes through SYNC_STAGES flops, giving `s`. A rising edge is detected when `s` is 1 and its previous registered value is 0. This gives a one-cycle `rise` flag.
- FSM states:
  - IDLE: counters held at 0. On `rise`: load pcnt←1 and hcnt←1, go to MEAS. No result is produced.
  - MEAS: each cycle pcnt increments; hcnt increments when `s`=1. Both saturate at 2^CNT_WIDTH−1.
  - In MEAS with `rise`: emit result (period=pcnt, high_time=hcnt, ovf=0), then reload pcnt←1 and hcnt←1. Stay in MEAS.
  - In MEAS with pcnt = 2^CNT_WIDTH−1 and no `rise`: emit result (period=2^CNT_WIDTH−1, high_time=hcnt, ovf=1), then go to IDLE.
- Result definition: for rising edges detected at cycles t1 and t2:
  - period = t2−t1
  - high_time = number of cycles in [t1, t2−1] with `s`=1, so 1 ≤ high_time ≤ period.
- The maximum measurable period is 2^CNT_WIDTH−1. A rise arriving exactly at pcnt=2^CNT_WIDTH−1 gives a valid result with ovf=0.
- en=0:
  - FSM is forced to IDLE and counters are cleared.
  - The synchroniser keeps running.
  - A pending result stays held on the output.
  - On return to en=1, the first rise only starts a new measurement.
- Output slot (one entry):
  - An emitted result loads the slot when the slot is empty or is being accepted that cycle (m_valid & m_ready).
  - Otherwise the result is discarded and lost←1.
  - Data fields are stable while m_valid=1 and m_ready=0.
  - On acceptance, lost←0 unless a discard happens in the same cycle.
  - A simultaneous accept and new result loads the new result, keeps m_valid=1 and causes no discard.
- Reset values:
  - m_valid=0, period=0, high_time=0, ovf=0, lost=0
  - FSM=IDLE, synchroniser and edge registers 0

## Timing
- Sync latency: if the first synchroniser flop captures SIG=1 at CLK edge k, then `rise` is true in the cycle after edge k+SYNC_STAGES−1.
- Result latency: m_valid rises after edge k+SYNC_STAGES for the closing edge of the period.
- Timeout result: m_valid rises one edge after the cycle in which pcnt reached 2^CNT_WIDTH−1.
- Throughput: one result per rise; the minimum measurable period is 2 cycles.
- m_valid remains 1 until the edge where m_valid & m_ready is sampled. It falls after that edge unless a new result loads in the same cycle.
- RST mid-measurement: all state clears immediately and asynchronously. Any pending result is discarded without setting lost.

## Test plan
- Periodic input: en=1, SIG with a 10-cycle period and 3 cycles high, m_ready=1, CNT_WIDTH=16. Required:
  - no result for the first edge
  - then every result has period=10, high_time=3, ovf=0, lost=0
  - m_valid appears SYNC_STAGES edges after SIG is sampled high.
- Saturation boundary, CNT_WIDTH=4, m_ready=1:
  - SIG with a 15-cycle period → period=15, ovf=0.
  - One rise, then SIG held low → one result with period=15, high_time=1, ovf=1, FSM returns to IDLE.
  - The next rise produces no result.
- Backpressure, m_ready=0, SIG period 6:
  - the first result is held stable
  - later results are dropped and lost=1
  - after raising m_ready for one cycle, the first result is accepted and lost=0.
- Simultaneous accept and capture: assert m_ready exactly in the cycle a new result is emitted. Required: the new result loads, m_valid stays 1, lost stays 0.
- en and reset mid-measurement:
  - drop en for 3 cycles mid-period → no result for the interrupted period; the next rise restarts measurement.
  - assert RST while m_valid=1 → all outputs 0 immediately; after release the first rise yields no result.
